// File: rtl/iot_event_encoder.sv
// Serialises per-device activity-flag transitions into a change/on_off event stream.
// One event per clock, granted round-robin, with a running count of reported-on devices.
module iot_event_encoder #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N-1:0]     devices_in,
    output logic             change,
    output logic             on_off,
    output logic             pending,
    output logic [CNT_W-1:0] reported_count
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     dev_q;
    logic [N-1:0]     reported_q;
    logic [N-1:0]     reported_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             change_q;
    logic             change_d;
    logic             on_off_q;
    logic             on_off_d;
    logic             pending_q;
    logic             pending_d;

    logic [N-1:0]     pend;
    logic             hi_vld;
    logic             lo_vld;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;
    logic [PTR_W-1:0] grant;
    logic             grant_vld;

    assign pend = dev_q ^ reported_q;

    // Round-robin pick: first pending index at or above ptr, else first pending from 0.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!hi_vld && pend[i] && (PTR_W'(i) >= ptr_q)) begin
                hi_vld = 1'b1;
                hi_idx = PTR_W'(i);
            end
            if (!lo_vld && pend[i]) begin
                lo_vld = 1'b1;
                lo_idx = PTR_W'(i);
            end
        end
        grant     = hi_vld ? hi_idx : lo_idx;
        grant_vld = lo_vld;
    end

    always_comb begin
        reported_d = reported_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        change_d   = 1'b0;
        on_off_d   = on_off_q;
        pending_d  = |pend;
        if (enable && grant_vld) begin
            change_d          = 1'b1;
            on_off_d          = dev_q[grant];
            reported_d[grant] = dev_q[grant];
            ptr_d             = (grant == PTR_W'(N - 1)) ? '0 : grant + PTR_W'(1);
            cnt_d             = dev_q[grant] ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_q      <= '0;
            reported_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            change_q   <= 1'b0;
            on_off_q   <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            dev_q      <= devices_in;
            reported_q <= reported_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            change_q   <= change_d;
            on_off_q   <= on_off_d;
            pending_q  <= pending_d;
        end
    end

    assign change         = change_q;
    assign on_off         = on_off_q;
    assign pending        = pending_q;
    assign reported_count = cnt_q;

endmodule

// File: tb/tb_iot_event_encoder.sv
// Bench for iot_event_encoder: reference model plus emulated monitor, checked every cycle,
// and directed sequences with literal expectations.
module tb_iot_event_encoder;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] devices_in;
    logic       change;
    logic       on_off;
    logic       pending;
    logic [7:0] reported_count;

    always #5 clk = ~clk;

    iot_event_encoder #(.N(8), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .devices_in     (devices_in),
        .change         (change),
        .on_off         (on_off),
        .pending        (pending),
        .reported_count (reported_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] m_dev;
    logic [7:0] m_rep;
    logic [7:0] m_pend;
    int         m_ptr;
    int         m_last_grant;
    int         m_g;
    bit         m_found;
    logic       exp_change;
    logic       exp_on_off;
    logic       exp_pending;
    int         mon_cnt;
    int         rc_prev;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the event rules, plus a monitor counter driven by the DUT's events.
    initial begin
        m_dev = '0; m_rep = '0; m_ptr = 0; m_last_grant = -1;
        exp_change = 1'b0; exp_on_off = 1'b0; exp_pending = 1'b0;
        mon_cnt = 0; rc_prev = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_dev = '0; m_rep = '0; m_ptr = 0;
                exp_change = 1'b0; exp_on_off = 1'b0; exp_pending = 1'b0;
                mon_cnt = 0; rc_prev = 0;
            end else begin
                if (change) mon_cnt += on_off ? 1 : -1;
                rc_prev     = reported_count;
                m_pend      = m_dev ^ m_rep;
                exp_pending = (m_pend != 0);
                exp_change  = 1'b0;
                if (enable && m_pend != 0) begin
                    m_found = 0;
                    m_g     = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!m_found && m_pend[(m_ptr + k) % N]) begin
                            m_found = 1;
                            m_g     = (m_ptr + k) % N;
                        end
                    end
                    exp_change   = 1'b1;
                    exp_on_off   = m_dev[m_g];
                    m_rep[m_g]   = m_dev[m_g];
                    m_ptr        = (m_g + 1) % N;
                    m_last_grant = m_g;
                end
                m_dev = devices_in;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("change", int'(change), int'(exp_change));
            check("on_off", int'(on_off), int'(exp_on_off));
            check("pending", int'(pending), int'(exp_pending));
            check("count_vs_model", int'(reported_count), $countones(m_rep));
            check("monitor", mon_cnt, rc_prev);
        end
    end

    int rr_exp[3] = '{6, 1, 3};

    initial begin
        rst = 1'b1; enable = 1'b1; devices_in = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_change", int'(change), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_count", int'(reported_count), 0);

        // All devices on at reset release: eight turn-ons in index order.
        rst = 1'b0;
        @(negedge clk);
        check("rel_latency", int'(change), 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("rel_change", int'(change), 1);
            check("rel_on_off", int'(on_off), 1);
            check("rel_count", int'(reported_count), k);
            check("rel_grant", m_last_grant, k - 1);
        end
        @(negedge clk);
        check("rel_done_change", int'(change), 0);
        check("rel_done_pending", int'(pending), 0);

        devices_in = 8'h00;
        repeat (12) @(negedge clk);
        check("all_off_count", int'(reported_count), 0);

        // Single-event latency, on then off.
        devices_in = 8'h04;
        @(negedge clk);
        check("lat_e0_change", int'(change), 0);
        @(negedge clk);
        check("lat_e1_change", int'(change), 1);
        check("lat_e1_on_off", int'(on_off), 1);
        check("lat_e1_count", int'(reported_count), 1);
        @(negedge clk);
        check("lat_single_pulse", int'(change), 0);
        devices_in = 8'h00;
        repeat (2) @(negedge clk);
        check("off_change", int'(change), 1);
        check("off_on_off", int'(on_off), 0);
        check("off_count", int'(reported_count), 0);

        // Round-robin from ptr=5.
        devices_in = 8'h10;
        repeat (2) @(negedge clk);
        check("rr_pre_grant", m_last_grant, 4);
        check("rr_pre_count", int'(reported_count), 1);
        devices_in = 8'h5A;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("rr_change", int'(change), 1);
            check("rr_grant", m_last_grant, rr_exp[j]);
            check("rr_count", int'(reported_count), 2 + j);
        end
        @(negedge clk);
        check("rr_done", int'(change), 0);
        devices_in = 8'h00;
        repeat (8) @(negedge clk);

        // Coalescing while disabled.
        enable = 1'b0;
        devices_in = 8'h04; repeat (2) @(negedge clk);
        devices_in = 8'h24; repeat (2) @(negedge clk);
        devices_in = 8'h20; repeat (2) @(negedge clk);
        check("coal_hold_change", int'(change), 0);
        check("coal_hold_pending", int'(pending), 1);
        check("coal_hold_count", int'(reported_count), 0);
        enable = 1'b1;
        @(negedge clk);
        check("coal_change", int'(change), 1);
        check("coal_on_off", int'(on_off), 1);
        check("coal_count", int'(reported_count), 1);
        check("coal_grant", m_last_grant, 5);
        @(negedge clk);
        check("coal_one_event", int'(change), 0);
        check("coal_pending", int'(pending), 0);

        // Hold with three more devices on.
        enable = 1'b0;
        devices_in = 8'h27;
        repeat (3) @(negedge clk);
        check("hold_change", int'(change), 0);
        check("hold_pending", int'(pending), 1);
        check("hold_count", int'(reported_count), 1);
        enable = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("hold_rel_change", int'(change), 1);
            check("hold_rel_count", int'(reported_count), k);
        end
        @(negedge clk);
        check("hold_rel_done", int'(change), 0);

        // Random traffic with a mid-run reset; model and monitor checked every cycle.
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            devices_in = 8'($urandom);
            enable     = ($urandom_range(0, 3) != 0);
            if (c == 250) rst = 1'b1;
            if (c == 252) rst = 1'b0;
        end

        // Recovery after reset with stable inputs.
        devices_in = 8'hB5;
        enable     = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 2) @(negedge clk);
        check("recovery_count", int'(reported_count), 5);
        check("recovery_pending", int'(pending), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
